// File: rtl/wb_pbus_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pbus_master_pkg
// Description : Shared types and constants for the Wishbone peripheral-bus
//               master: FSM state encoding, bus widths, the default ACK
//               timeout and the wait-counter load helper.
// Revision    : 1.0  initial release
// ============================================================================
package wb_pbus_master_pkg;

    localparam int c_ADR_W       = 12;   // 4K peripheral window
    localparam int c_DAT_W       = 8;
    localparam int c_WAIT_W      = 7;    // async extra wait cycles
    localparam int c_CNT_W       = 8;    // wait/timeout counter
    localparam int c_TIMEOUT_DEF = 255;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } pbus_state_t;

    // The counter reaches zero in the last BUS cycle, so it is loaded with
    // (cycles - 1): N for async (N+1 cycles), TIMEOUT-1 for sync.
    function automatic logic [c_CNT_W-1:0] f_load_value(
        input logic                sync_mode,
        input logic [c_WAIT_W-1:0] wait_n,
        input int                  timeout
    );
        logic [c_CNT_W-1:0] v;
        if (sync_mode) v = c_CNT_W'(timeout - 1);
        else           v = {1'b0, wait_n};
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_pbus_master_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_pbus_master_if
// Description : CPU-side request port plus Wishbone classic master port.
//               modport master : the bus master (drives WB_* outputs and
//                                CPU completion/status)
//               modport slave  : the environment (CPU and Wishbone slave)
// Revision    : 1.0  initial release
// ============================================================================
interface wb_pbus_master_if;
    import wb_pbus_master_pkg::*;

    // CPU side
    logic                CPU_REQ;
    logic                CPU_WE;
    logic [c_ADR_W-1:0]  CPU_ADR;
    logic [c_DAT_W-1:0]  CPU_WDAT;
    logic [c_DAT_W-1:0]  CPU_RDAT;
    logic                CPU_BUSY;
    logic                CPU_DONE;
    logic                CPU_ERR;
    logic                SYNC_MODE;
    logic [c_WAIT_W-1:0] ASYNC_WAITCYCLE;

    // Wishbone side
    logic [c_ADR_W-1:0]  WB_ADRo;
    logic [c_DAT_W-1:0]  WB_DATo;
    logic [c_DAT_W-1:0]  WB_DATi;
    logic                WB_WEo;
    logic                WB_CYCo;
    logic                WB_STBo;
    logic                WB_ACKi;

    modport master (
        input  CPU_REQ, CPU_WE, CPU_ADR, CPU_WDAT, SYNC_MODE, ASYNC_WAITCYCLE,
        input  WB_DATi, WB_ACKi,
        output CPU_RDAT, CPU_BUSY, CPU_DONE, CPU_ERR,
        output WB_ADRo, WB_DATo, WB_WEo, WB_CYCo, WB_STBo
    );

    modport slave (
        output CPU_REQ, CPU_WE, CPU_ADR, CPU_WDAT, SYNC_MODE, ASYNC_WAITCYCLE,
        output WB_DATi, WB_ACKi,
        input  CPU_RDAT, CPU_BUSY, CPU_DONE, CPU_ERR,
        input  WB_ADRo, WB_DATo, WB_WEo, WB_CYCo, WB_STBo
    );

endinterface
`default_nettype wire

// File: rtl/wb_pbus_master_wait_cnt.sv
`default_nettype none
// ============================================================================
// Module      : pbus_wait_cnt
// Description : 8-bit load/decrement counter shared by the async wait count
//               and the sync ACK timeout. Load has priority; decrement
//               saturates at zero.
//   clk, rst : clock, asynchronous active-high reset
//   load     : load counter with value
//   value    : load value
//   en       : decrement enable
//   zero     : counter equals zero
// Revision    : 1.0  initial release
// ============================================================================
module pbus_wait_cnt
    import wb_pbus_master_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               load,
    input  wire logic [c_CNT_W-1:0] value,
    input  wire logic               en,
    output wire logic               zero
);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= value;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/wb_pbus_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_pbus_master
// Description : Converts single CPU requests into single, non-pipelined
//               Wishbone classic cycles. Sync mode ends on ACK (or aborts
//               after TIMEOUT cycles, setting a sticky error); async mode
//               ends after a fixed N+1 cycles with ACK ignored.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : wb_pbus_master_if.master (CPU request/status + Wishbone)
//   TIMEOUT  : sync-mode bus cycles without ACK before abort (1..255)
// Revision    : 1.0  initial release
// ============================================================================
module wb_pbus_master
    import wb_pbus_master_pkg::*;
#(
    parameter int TIMEOUT = c_TIMEOUT_DEF
)(
    input  wire logic         clk,
    input  wire logic         rst,
    wb_pbus_master_if.master  bus
);

    pbus_state_t          r_state;
    logic                 r_sync;
    logic                 r_cyc;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic                 r_wb_we;
    logic [c_ADR_W-1:0]   r_wb_adr;
    logic [c_DAT_W-1:0]   r_wb_dat;
    logic [c_DAT_W-1:0]   r_rdat;

    logic                 w_accept;
    logic                 w_cnt_zero;
    logic [c_CNT_W-1:0]   w_load_val;

    assign w_accept   = (r_state == ST_IDLE) && bus.CPU_REQ;
    assign w_load_val = f_load_value(bus.SYNC_MODE, bus.ASYNC_WAITCYCLE, TIMEOUT);

    pbus_wait_cnt u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (w_accept),
        .value (w_load_val),
        .en    (r_state == ST_BUS),
        .zero  (w_cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sync   <= 1'b0;
            r_cyc    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_wb_we  <= 1'b0;
            r_wb_adr <= '0;
            r_wb_dat <= '0;
            r_rdat   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state  <= ST_BUS;
                        r_sync   <= bus.SYNC_MODE;
                        r_wb_we  <= bus.CPU_WE;
                        r_wb_adr <= bus.CPU_ADR;
                        r_wb_dat <= bus.CPU_WDAT;
                        r_err    <= 1'b0;
                        r_cyc    <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ST_BUS: begin
                    // ACK wins over an expiring timeout on the same edge.
                    if ((r_sync && bus.WB_ACKi) || w_cnt_zero) begin
                        r_state <= ST_IDLE;
                        r_cyc   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_wb_we <= 1'b0;
                        r_done  <= 1'b1;
                        if (r_sync && !bus.WB_ACKi) begin
                            r_err <= 1'b1;
                            if (!r_wb_we) r_rdat <= '0;
                        end else if (!r_wb_we) begin
                            r_rdat <= bus.WB_DATi;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.WB_CYCo  = r_cyc;
    assign bus.WB_STBo  = r_cyc;
    assign bus.WB_WEo   = r_wb_we;
    assign bus.WB_ADRo  = r_wb_adr;
    assign bus.WB_DATo  = r_wb_dat;
    assign bus.CPU_RDAT = r_rdat;
    assign bus.CPU_BUSY = r_busy;
    assign bus.CPU_DONE = r_done;
    assign bus.CPU_ERR  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_pbus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_pbus_master
// Description : Self-checking bench for wb_pbus_master. Directed scenarios
//               plus randomized transactions scored against a transaction-
//               level model (expected bus length, read data, error flag).
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_pbus_master;

    localparam int TMO = 255;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [7:0] m_rdat;   // model of CPU_RDAT

    wb_pbus_master_if bus ();

    wb_pbus_master #(.TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction, started at #1 after a rising edge in IDLE and
    // finished at #1 after a rising edge in IDLE. ackc = cycle (1-based)
    // in which ACK is raised in sync mode; 0 = never.
    task automatic do_txn(input logic we, input logic [11:0] adr, input logic [7:0] wd,
                          input logic sync, input logic [6:0] n, input int ackc,
                          input logic [7:0] di);
        int         len_exp;
        int         len_obs;
        logic       tmo;
        logic       stable;
        logic       broke;
        logic [7:0] rd_exp;

        tmo     = sync && !(ackc >= 1 && ackc <= TMO);
        len_exp = !sync ? int'(n) + 1 : (tmo ? TMO : ackc);
        rd_exp  = we ? m_rdat : (tmo ? 8'h00 : di);

        bus.CPU_REQ         = 1'b1;
        bus.CPU_WE          = we;
        bus.CPU_ADR         = adr;
        bus.CPU_WDAT        = wd;
        bus.SYNC_MODE       = sync;
        bus.ASYNC_WAITCYCLE = n;
        bus.WB_ACKi         = 1'b0;
        @(posedge clk); #1;
        bus.CPU_REQ = 1'b0;

        len_obs = 0;
        stable  = 1'b1;
        broke   = 1'b0;
        for (int k = 1; k <= len_exp + 3; k++) begin
            bus.WB_ACKi         = sync ? (k == ackc) : 1'($urandom);
            bus.WB_DATi         = (k == len_exp) ? di : 8'($urandom);
            bus.SYNC_MODE       = 1'($urandom);
            bus.ASYNC_WAITCYCLE = 7'($urandom);
            bus.CPU_WE          = 1'($urandom);
            bus.CPU_ADR         = 12'($urandom);
            bus.CPU_WDAT        = 8'($urandom);
            @(negedge clk);
            if (!bus.WB_CYCo) begin
                broke = 1'b1;
                break;
            end
            len_obs++;
            if (k == 1) check_eq("err_clear_on_accept", bus.CPU_ERR, 1'b0);
            if (bus.WB_ADRo !== adr || bus.WB_DATo !== wd || bus.WB_WEo !== we ||
                bus.WB_STBo !== 1'b1 || bus.CPU_BUSY !== 1'b1 || bus.CPU_DONE !== 1'b0)
                stable = 1'b0;
            @(posedge clk); #1;
        end
        check_eq("bus_len", len_obs, len_exp);
        check_eq("bus_stable", stable, 1'b1);
        if (broke) begin
            check_eq("done_pulse", bus.CPU_DONE, 1'b1);
            check_eq("busy_at_done", bus.CPU_BUSY, 1'b0);
            check_eq("we_idle", bus.WB_WEo, 1'b0);
            check_eq("rdat", bus.CPU_RDAT, rd_exp);
            check_eq("err", bus.CPU_ERR, tmo);
            @(posedge clk); #1;
            @(negedge clk);
            check_eq("done_one_cycle", bus.CPU_DONE, 1'b0);
            @(posedge clk); #1;
        end
        m_rdat      = rd_exp;
        bus.WB_ACKi = 1'b0;
    endtask

    initial begin
        logic [11:0] b2b_adr [1:9];
        logic        e_c;
        logic        e_d;
        logic        quiet;

        n_checks = 0;
        n_errors = 0;
        m_rdat   = 8'h00;

        bus.CPU_REQ = 1'b0; bus.CPU_WE = 1'b0; bus.CPU_ADR = '0; bus.CPU_WDAT = '0;
        bus.SYNC_MODE = 1'b1; bus.ASYNC_WAITCYCLE = '0; bus.WB_DATi = '0; bus.WB_ACKi = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cyc",  {bus.WB_CYCo, bus.WB_STBo, bus.WB_WEo}, 3'b000);
        check_eq("rst_adr",  bus.WB_ADRo, 12'h000);
        check_eq("rst_dato", bus.WB_DATo, 8'h00);
        check_eq("rst_rdat", bus.CPU_RDAT, 8'h00);
        check_eq("rst_stat", {bus.CPU_BUSY, bus.CPU_DONE, bus.CPU_ERR}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Sync read, ACK in first cycle
        do_txn(1'b0, 12'h805, 8'h00, 1'b1, 7'd0, 1, 8'h5A);
        // Async write, N=5 (ACK noise ignored)
        do_txn(1'b1, 12'h600, 8'h3C, 1'b0, 7'd5, 0, 8'hEE);
        // Async read, N=0
        do_txn(1'b0, 12'h0AB, 8'h00, 1'b0, 7'd0, 0, 8'hC3);
        // Sync read timeout, then a request that clears ERR
        do_txn(1'b0, 12'hFFF, 8'h00, 1'b1, 7'd0, 0, 8'hA5);
        do_txn(1'b1, 12'h001, 8'h99, 1'b1, 7'd0, 4, 8'h00);
        // Sync write timeout leaves RDAT alone
        do_txn(1'b0, 12'h010, 8'h00, 1'b1, 7'd0, 2, 8'h77);
        do_txn(1'b1, 12'h020, 8'h55, 1'b1, 7'd0, 0, 8'h00);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            logic s;
            s = 1'($urandom);
            do_txn(1'($urandom), 12'($urandom), 8'($urandom), s,
                   7'($urandom_range(0, 20)), s ? int'($urandom_range(0, 12)) : 0,
                   8'($urandom));
        end

        // Back-to-back: REQ held high, async N=2 writes
        bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b1; bus.CPU_ADR = 12'h111; bus.CPU_WDAT = 8'h11;
        bus.SYNC_MODE = 1'b0; bus.ASYNC_WAITCYCLE = 7'd2;
        @(posedge clk); #1;
        bus.CPU_ADR = 12'h222; bus.CPU_WDAT = 8'h22;
        for (int k = 1; k <= 9; k++) begin
            if (k == 5) bus.CPU_REQ = 1'b0;
            @(negedge clk);
            e_c = (k <= 3) || (k >= 5 && k <= 7);
            e_d = (k == 4) || (k == 8);
            check_eq("b2b_cyc_done", {bus.WB_CYCo, bus.CPU_DONE}, {e_c, e_d});
            b2b_adr[k] = bus.WB_ADRo;
            @(posedge clk); #1;
        end
        check_eq("b2b_adr_first",  b2b_adr[2], 12'h111);
        check_eq("b2b_adr_second", b2b_adr[6], 12'h222);

        // Reset in the middle of an N=10 async access
        bus.CPU_REQ = 1'b1; bus.CPU_WE = 1'b1; bus.CPU_ADR = 12'h3A5; bus.CPU_WDAT = 8'h6B;
        bus.SYNC_MODE = 1'b0; bus.ASYNC_WAITCYCLE = 7'd10;
        @(posedge clk); #1;
        bus.CPU_REQ = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("mid_rst_pre_cyc", bus.WB_CYCo, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_cyc",  {bus.WB_CYCo, bus.WB_STBo, bus.WB_WEo}, 3'b000);
        check_eq("mid_rst_adr",  bus.WB_ADRo, 12'h000);
        check_eq("mid_rst_dato", bus.WB_DATo, 8'h00);
        check_eq("mid_rst_rdat", bus.CPU_RDAT, 8'h00);
        check_eq("mid_rst_stat", {bus.CPU_BUSY, bus.CPU_DONE, bus.CPU_ERR}, 3'b000);
        m_rdat = 8'h00;
        @(posedge clk); #1;
        rst   = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.WB_CYCo !== 1'b0 || bus.CPU_DONE !== 1'b0) quiet = 1'b0;
        end
        check_eq("mid_rst_no_done", quiet, 1'b1);
        @(posedge clk); #1;

        // Normal operation after the abort
        do_txn(1'b0, 12'h444, 8'h00, 1'b1, 7'd0, 3, 8'h81);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_pbus_master.md
WB_PBUS_MASTER -- requirements
Module: wb_pbus_master

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning the number of sync-mode bus cycles without ACK before the transaction is aborted (range 1..255).
REQ-002 clk  input  1  system core clock; all logic is rising-edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 CPU_REQ  input  1  single-cycle transaction request; sampled only in IDLE.
REQ-005 CPU_WE  input  1  1=write, 0=read; sampled with CPU_REQ.
REQ-006 CPU_ADR  input  12  target address, 4K peripheral window.
REQ-007 CPU_WDAT  input  8  write data.
REQ-008 CPU_RDAT  output  8  read data, registered, valid while CPU_DONE=1 and held until the next completion.
REQ-009 CPU_BUSY  output  1  high while a transaction is in flight.
REQ-010 CPU_DONE  output  1  one-cycle completion pulse.
REQ-011 CPU_ERR  output  1  sticky timeout flag.
REQ-012 SYNC_MODE  input  1  1=terminate on WB_ACKi, 0=terminate after a fixed wait count.
REQ-013 ASYNC_WAITCYCLE  input  7  extra wait cycles N in async mode.
REQ-014 WB_ADRo  output  12  Wishbone address.
REQ-015 WB_DATo  output  8  Wishbone write data.
REQ-016 WB_DATi  input  8  Wishbone read data.
REQ-017 WB_WEo  output  1  Wishbone write enable.
REQ-018 WB_CYCo  output  1  Wishbone cycle.
REQ-019 WB_STBo  output  1  Wishbone strobe, always equal to WB_CYCo.
REQ-020 WB_ACKi  input  1  Wishbone acknowledge; may be combinationally high.

Function
REQ-021 FSM states are IDLE and BUS; the block issues only single, non-pipelined Wishbone classic cycles.
REQ-022 IDLE with CPU_REQ=1 at edge T: latch CPU_ADR, CPU_WE, CPU_WDAT and SYNC_MODE; load the cycle counter; clear CPU_ERR; enter BUS. In cycle T+1, WB_CYCo, WB_STBo, CPU_BUSY=1.
REQ-023 WB_ADRo, WB_DATo and WB_WEo come only from the latched values and stay stable through BUS. WB_WEo=0 and WB_CYCo=0 outside BUS.
REQ-024 Sync mode: on the first BUS edge where WB_ACKi=1, capture WB_DATi into CPU_RDAT (reads only) and return to IDLE. With ACK tied high, CYC is high for exactly one cycle (T+1) and CPU_DONE=1 at T+2.
REQ-025 Sync timeout: if WB_ACKi is not seen within TIMEOUT BUS cycles, return to IDLE, set CPU_ERR=1, pulse CPU_DONE, and load CPU_RDAT=8'h00 for reads.
REQ-026 Async mode: WB_ACKi is ignored; BUS lasts exactly N+1 cycles (T+1..T+N+1), WB_DATi is sampled on the last BUS edge, and CPU_DONE=1 at T+N+2. N=0 gives a one-cycle access.
REQ-027 CPU_DONE is high for exactly one cycle, the first IDLE cycle after BUS; CPU_BUSY=0 in that same cycle.
REQ-028 CPU_REQ in the CPU_DONE cycle is accepted, so WB_CYCo is low for at least one cycle between transactions.
REQ-029 CPU_REQ while in BUS is ignored and is not queued.
REQ-030 Writes leave CPU_RDAT unchanged.
REQ-031 Changes to SYNC_MODE or ASYNC_WAITCYCLE during BUS have no effect on the current transaction.
REQ-032 CPU_ERR stays set until the next accepted request.

Reset
REQ-033 rst forces immediate (asynchronous) entry to IDLE, with WB_CYCo/WB_STBo/WB_WEo=0, WB_ADRo=12'h000, WB_DATo=8'h00, CPU_RDAT=8'h00, CPU_BUSY=CPU_DONE=CPU_ERR=0 and counter=0.
REQ-034 Reset during BUS aborts the cycle without a CPU_DONE pulse.

Structure
REQ-035 The shared package holds the FSM state encoding, the TIMEOUT default, and the width constants: 12 for address, 8 for data, 7 for wait count.
REQ-036 The 8-bit load/decrement wait-and-timeout counter is a sub-module, pbus_wait_cnt, with inputs load, value and en, and output zero.

Verification
REQ-037 Sync read: ACK tied 1, ADR=12'h805, DATi=8'h5A -> CYC high 1 cycle, DONE at T+2, RDAT=8'h5A, ERR=0.
REQ-038 Async write: SYNC_MODE=0, N=5, ADR=12'h600, WDAT=8'h3C -> CYC high 6 cycles with ADR/DATo/WE stable, DONE at T+7, ACK ignored.
REQ-039 Timeout: SYNC_MODE=1, ACK held 0, TIMEOUT=255 -> CYC drops after 255 cycles, DONE pulse, ERR=1, RDAT=8'h00; the next request clears ERR.
REQ-040 Back-to-back: REQ held high across two transactions -> second accepted in the DONE cycle, one CYC-low gap, second REQ during BUS ignored.
REQ-041 Reset mid-BUS: assert rst at cycle T+3 of an N=10 access -> CYC low within the same cycle, no DONE, all outputs at reset values.
REQ-042 Mode change: toggle SYNC_MODE and ASYNC_WAITCYCLE during BUS -> duration follows the values latched at accept.
